// File: rtl/relm_div_seq.sv
// relm_div_seq: sequential radix-2 restoring divider with unsigned, signed
// and fractional-unsigned modes. One quotient bit is produced per cycle,
// MSB first. Divide-by-zero, signed MIN/-1 and fractional-overflow results
// are substituted in FIX, so the latency is the same for every operand.
module relm_div_seq #(
  parameter int WD = 32,
  parameter int WC = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_in,
  input  logic [1:0]    mode_in,
  input  logic [WD-1:0] a_in,
  input  logic [WD-1:0] b_in,
  output logic          ready_out,
  output logic          valid_out,
  output logic [WD-1:0] q_out,
  output logic [WD-1:0] r_out,
  output logic          dbz_out,
  output logic          ovf_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] ITER = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  localparam logic [1:0] MODE_SGN  = 2'd1;
  localparam logic [1:0] MODE_FRAC = 2'd2;

  localparam logic [WC-1:0] CNT_LAST = WC'(WD - 1);
  localparam logic [WD-1:0] MIN_VAL  = {1'b1, {(WD-1){1'b0}}};

  logic [1:0]      state;
  logic [1:0]      mode;
  logic [WD-1:0]   a_raw;
  logic [WD-1:0]   b_raw;
  logic [WD-1:0]   div;
  logic [2*WD-1:0] prem;
  logic            q_neg;
  logic            r_neg;
  logic [WC-1:0]   cnt;

  logic            is_sgn;
  logic            is_frac;
  logic [WD-1:0]   a_abs;
  logic [WD-1:0]   b_abs;
  logic [WD:0]     upper;
  logic [WD-1:0]   diff;
  logic            fits;
  logic [2*WD-1:0] prem_next;
  logic [WD-1:0]   q_mag;
  logic [WD-1:0]   r_mag;

  assign ready_out = (state == IDLE);
  assign is_sgn    = (mode == MODE_SGN);
  assign is_frac   = (mode == MODE_FRAC);

  // The low half of the partial remainder collects quotient bits, the high
  // half holds the running remainder once all WD steps are done.
  assign q_mag = prem[WD-1:0];
  assign r_mag = prem[2*WD-1:WD];

  // Operand magnitudes; only signed mode strips the sign.
  always_comb begin
    a_abs = a_raw;
    b_abs = b_raw;
    if (is_sgn && a_raw[WD-1]) a_abs = -a_raw;
    if (is_sgn && b_raw[WD-1]) b_abs = -b_raw;
  end

  // One restoring step: shift left, subtract the divisor if it fits.
  always_comb begin
    upper     = prem[2*WD-1:WD-1];
    fits      = (upper >= {1'b0, div});
    diff      = upper[WD-1:0] - div;
    prem_next = fits ? {diff, prem[WD-2:0], 1'b1} : {prem[2*WD-2:0], 1'b0};
  end

  // Control FSM and iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode  <= 2'd0;
      a_raw <= '0;
      b_raw <= '0;
      div   <= '0;
      prem  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            a_raw <= a_in;
            b_raw <= b_in;
            mode  <= (mode_in == 2'b11) ? 2'b00 : mode_in;
            state <= PREP;
          end
        end
        PREP: begin
          prem  <= is_frac ? {a_raw, {WD{1'b0}}} : {{WD{1'b0}}, a_abs};
          div   <= b_abs;
          q_neg <= is_sgn & (a_raw[WD-1] ^ b_raw[WD-1]);
          r_neg <= is_sgn & a_raw[WD-1];
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          prem <= prem_next;
          cnt  <= cnt + WC'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result registers: written only in FIX, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      q_out     <= '0;
      r_out     <= '0;
      dbz_out   <= 1'b0;
      ovf_out   <= 1'b0;
    end else if (state == FIX) begin
      valid_out <= 1'b1;
      dbz_out   <= 1'b0;
      ovf_out   <= 1'b0;
      if (b_raw == '0) begin
        q_out   <= '1;
        r_out   <= a_raw;
        dbz_out <= 1'b1;
      end else if (is_frac && (a_raw >= b_raw)) begin
        q_out   <= '1;
        r_out   <= a_raw;
        ovf_out <= 1'b1;
      end else if (is_sgn && (a_raw == MIN_VAL) && (b_raw == '1)) begin
        q_out   <= MIN_VAL;
        r_out   <= '0;
        ovf_out <= 1'b1;
      end else begin
        q_out <= q_neg ? -q_mag : q_mag;
        r_out <= r_neg ? -r_mag : r_mag;
      end
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relm_div_seq.sv
// tb_relm_div_seq: scoreboard bench for relm_div_seq (WD=32). The driver
// pushes expected results when an operation is accepted; a separate monitor
// pops and compares whenever valid_out is seen.
module tb_relm_div_seq;
  localparam int WD  = 32;
  localparam int LAT = WD + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic [1:0]    mode_in = 2'd0;
  logic [WD-1:0] a_in = '0;
  logic [WD-1:0] b_in = '0;
  logic          ready_out;
  logic          valid_out;
  logic [WD-1:0] q_out;
  logic [WD-1:0] r_out;
  logic          dbz_out;
  logic          ovf_out;

  typedef struct {
    logic [WD-1:0] q;
    logic [WD-1:0] r;
    logic          dbz;
    logic          ovf;
    int            due;
    int            id;
  } exp_t;

  typedef struct {
    logic [WD-1:0] a;
    logic [WD-1:0] b;
    logic [1:0]    m;
    logic [WD-1:0] q;
    logic [WD-1:0] r;
    logic          dbz;
    logic          ovf;
  } vec_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            op_id = 0;
  logic [WD-1:0] last_q = '0;
  logic [WD-1:0] last_r = '0;
  logic          last_dbz = 1'b0;
  logic          last_ovf = 1'b0;

  relm_div_seq #(.WD(WD), .WC(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_in  (start_in),
    .mode_in   (mode_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .q_out     (q_out),
    .r_out     (r_out),
    .dbz_out   (dbz_out),
    .ovf_out   (ovf_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic on the operand values.
  task automatic refModel(input logic [WD-1:0] a, input logic [WD-1:0] b,
                          input logic [1:0] m, output logic [WD-1:0] q,
                          output logic [WD-1:0] r, output logic dbz,
                          output logic ovf);
    logic [2*WD-1:0] n;
    logic [2*WD-1:0] t;
    longint sa, sbv, sq, sr;
    dbz = 1'b0;
    ovf = 1'b0;
    if (b == '0) begin
      q = '1; r = a; dbz = 1'b1;
    end else if (m == 2'd1) begin
      if (a == {1'b1, {(WD-1){1'b0}}} && b == '1) begin
        q = {1'b1, {(WD-1){1'b0}}}; r = '0; ovf = 1'b1;
      end else begin
        sa = $signed(a);
        sbv = $signed(b);
        sq = sa / sbv;
        sr = sa % sbv;
        q = sq[WD-1:0];
        r = sr[WD-1:0];
      end
    end else if (m == 2'd2) begin
      if (a >= b) begin
        q = '1; r = a; ovf = 1'b1;
      end else begin
        n = {a, {WD{1'b0}}};
        t = n / {{WD{1'b0}}, b};
        q = t[WD-1:0];
        t = n % {{WD{1'b0}}, b};
        r = t[WD-1:0];
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Wait for ready, scribbling on the inputs while busy, then issue one op.
  task automatic applyStimulus(input logic [WD-1:0] a, input logic [WD-1:0] b,
                               input logic [1:0] m, input logic [WD-1:0] eq,
                               input logic [WD-1:0] er, input logic edbz,
                               input logic eovf);
    exp_t e;
    int waited = 0;
    @(negedge clk);
    while (!(ready_out && rst_n)) begin
      start_in = 1'($urandom_range(0, 1));
      a_in     = $urandom;
      b_in     = $urandom;
      mode_in  = 2'($urandom_range(0, 3));
      waited++;
      if (waited > 4 * LAT) begin
        tests++; fails++;
        $display("[TB] FAIL ready_wait: ready_out stayed %b for %0d cycles, need 1", ready_out, waited);
        return;
      end
      @(negedge clk);
    end
    a_in = a; b_in = b; mode_in = m; start_in = 1'b1;
    e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
    e.due = cyc + 1 + LAT;
    e.id = op_id++;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    tests++;
    if (q_out !== e.q || r_out !== e.r || dbz_out !== e.dbz || ovf_out !== e.ovf) begin
      fails++;
      $display("[TB] FAIL result op%0d: got q=%h r=%h dbz=%b ovf=%b, need q=%h r=%h dbz=%b ovf=%b",
               e.id, q_out, r_out, dbz_out, ovf_out, e.q, e.r, e.dbz, e.ovf);
    end
    tests++;
    if (cyc != e.due) begin
      fails++;
      $display("[TB] FAIL latency op%0d: valid at cycle %0d, need %0d", e.id, cyc, e.due);
    end
    tests++;
    if (ready_out !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_on_valid op%0d: ready_out=%b, need 1", e.id, ready_out);
    end
  endtask

  task automatic checkReset(input string tag);
    tests++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0 || q_out !== '0 || r_out !== '0 ||
        dbz_out !== 1'b0 || ovf_out !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s: got ready=%b valid=%b q=%h r=%h dbz=%b ovf=%b, need 1 0 0 0 0 0",
               tag, ready_out, valid_out, q_out, r_out, dbz_out, ovf_out);
    end
  endtask

  // Monitor: pops on valid_out, checks output hold and bounded latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid_out) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL spurious_valid: valid_out=1 at cycle %0d, need 0 (nothing pending)", cyc);
          end else begin
            e = sb.pop_front();
            checkOutput(e);
          end
        end else begin
          tests++;
          if (q_out !== last_q || r_out !== last_r || dbz_out !== last_dbz || ovf_out !== last_ovf) begin
            fails++;
            $display("[TB] FAIL hold: outputs changed without valid at cycle %0d, got q=%h r=%h, need q=%h r=%h",
                     cyc, q_out, r_out, last_q, last_r);
          end
          if (sb.size() > 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            tests++; fails++;
            $display("[TB] FAIL timeout op%0d: no valid by cycle %0d, need valid at %0d", e.id, cyc, e.due);
          end
        end
      end
      last_q = q_out; last_r = r_out; last_dbz = dbz_out; last_ovf = ovf_out;
    end
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [WD-1:0] a, b, q, r;
    logic [1:0] m;
    logic dbz, ovf;
    int sel, drain;
    exp_t e;

    vecs.push_back('{32'd100,        32'd7,          2'd0, 32'd14,         32'd2,          1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          2'd1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  2'd1, 32'h8000_0000,  32'd0,          1'b0, 1'b1});
    vecs.push_back('{32'd5,          32'd0,          2'd0, 32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0});
    vecs.push_back('{32'd1,          32'd3,          2'd2, 32'h5555_5555,  32'd1,          1'b0, 1'b0});
    vecs.push_back('{32'd3,          32'd3,          2'd2, 32'hFFFF_FFFF,  32'd3,          1'b0, 1'b1});
    vecs.push_back('{32'd100,        32'd7,          2'd3, 32'd14,         32'd2,          1'b0, 1'b0});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE,  2'd1, 32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000,  32'd0,          2'd1, 32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1'b0});
    vecs.push_back('{32'd0,          32'd5,          2'd2, 32'd0,          32'd0,          1'b0, 1'b0});
    vecs.push_back('{32'h1234_5678,  32'd0,          2'd2, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1'b0});

    #3;
    checkReset("reset_state");
    @(negedge clk);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      applyStimulus(v.a, v.b, v.m, v.q, v.r, v.dbz, v.ovf);
    end

    // Reset around iteration 10 of an operation, then restart straight away.
    applyStimulus(32'd1000, 32'd9, 2'd0, 32'd111, 32'd1, 1'b0, 1'b0);
    repeat (12) begin
      @(negedge clk);
      start_in = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 checkReset("reset_midop");
    sb.delete();
    repeat (2) @(negedge clk);
    a_in = 32'hFFFF_FF9C; b_in = 32'd7; mode_in = 2'd1; start_in = 1'b1;
    refModel(a_in, b_in, mode_in, q, r, dbz, ovf);
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
    e.due = cyc + 1 + LAT;
    e.id = op_id++;
    sb.push_back(e);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      m = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case (sel)
        0: b = '0;
        1: b = WD'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = '1; m = 2'd1; end
        3: b = WD'($urandom_range(1, 3)) << $urandom_range(0, 31);
        4, 5, 6, 7: if (m == 2'd2) begin b = $urandom | 32'd1; a = $urandom % b; end
        default: ;
      endcase
      refModel(a, b, m, q, r, dbz, ovf);
      applyStimulus(a, b, m, q, r, dbz, ovf);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          start_in = 1'b0;
        end
      end
    end

    @(negedge clk);
    start_in = 1'b0;
    drain = 0;
    while (sb.size() > 0 && drain < 4 * LAT) begin
      @(negedge clk);
      drain++;
    end
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("[TB] FAIL drain: %0d results still pending, need 0", sb.size());
    end
    repeat (2 * LAT) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
